// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the synchronous modulus counter.
// Exports direction/mode encodings and the load clamp function.
package cnt_pkg;

    // Direction encoding for up_dn
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Range-end behaviour encoding for sat_mode
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter the clamp helper supports; counters
    // narrower than this zero-extend into it.
    localparam int CNT_MAX_W = 32;

    // A loaded value above the terminal is pulled down to
    // the terminal so q never starts outside 0..mod_max.
    function automatic logic [CNT_MAX_W-1:0] clamp_load(
        input logic [CNT_MAX_W-1:0] val,
        input logic [CNT_MAX_W-1:0] max
    );
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// Ports: clk, reset (sync, active-high), en, clr (phase clear), tick.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // No phase to keep: every enabled cycle is a tick.
            assign tick = en;

            logic unused_ports;
            assign unused_ports = &{1'b0, clk, reset, clr};
        end else begin : g_div
            localparam int PC_W = $clog2(PRESCALE);
            localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

            logic [PC_W-1:0] pc;
            logic            last;

            assign last = (pc == PC_LAST);
            assign tick = en && last;

            // en low freezes the phase; clr restarts a full period.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pc <= '0;
                end else if (clr) begin
                    pc <= '0;
                end else if (en) begin
                    pc <= last ? '0 : pc + PC_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous up/down modulus counter with load, wrap/saturate and prescaler.
// Ports: clk, reset, en, up_dn, load, load_val, mod_max, sat_mode -> q, tc, wrap.
module sync_mod_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic             tick;
    logic             step;
    logic             at_top;
    logic             at_bot;
    logic             above;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    // A load in the same cycle swallows the tick.
    assign step = tick && !load;

    // q above mod_max happens only when mod_max is lowered
    // at runtime; counting up treats it as the terminal.
    assign at_top = (q >= mod_max);
    assign at_bot = (q == '0);
    assign above  = (q > mod_max);

    assign load_clamped = WIDTH'(clamp_load(CNT_MAX_W'(load_val),
                                            CNT_MAX_W'(mod_max)));

    assign tc = step && ((up_dn == DIR_UP) ? at_top : at_bot);

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = load_clamped;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (!at_top) begin
                    q_next = q + WIDTH'(1);
                end else if (sat_mode == MODE_SAT) begin
                    q_next = mod_max;
                end else begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (above) begin
                    // Pull back into range; not a wrap event.
                    q_next = mod_max;
                end else if (at_bot) begin
                    if (sat_mode == MODE_SAT) begin
                        q_next = '0;
                    end else begin
                        q_next    = mod_max;
                        wrap_next = 1'b1;
                    end
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_sync_mod_counter.sv
// Scoreboard bench for sync_mod_counter, PRESCALE=1 and PRESCALE=3 side by side.
// Directed scenarios then randomized traffic against an arithmetic model.
module tb_sync_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] mod_max;
    logic       sat_mode;
    logic [3:0] q1, q3;
    logic       tc1, tc3, wrap1, wrap3;

    sync_mod_counter #(.WIDTH(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .mod_max(mod_max),
        .sat_mode(sat_mode), .q(q1), .tc(tc1), .wrap(wrap1)
    );

    sync_mod_counter #(.WIDTH(4), .PRESCALE(3)) u_p3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .mod_max(mod_max),
        .sat_mode(sat_mode), .q(q3), .tc(tc3), .wrap(wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit w;
        bit tc;
        bit cs;
        bit ct;
    } rec_t;

    rec_t sb[2][$];

    int checks = 0;
    int errors = 0;

    int mq[2];
    bit mw[2];
    int ph[2];
    int pre[2] = '{1, 3};
    bit known = 0;

    int cur_mm;
    bit cur_s;

    task automatic cmp(input string nm, input int inst,
                       input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s[P%0d] t=%0t got %0d want %0d",
                     nm, pre[inst], $time, got, want);
        end
    endtask

    task automatic check(input int i, input rec_t x,
                         input logic [3:0] aq, input logic aw,
                         input logic atc);
        if (x.cs) begin
            cmp("q", i, int'(aq), x.q);
            cmp("wrap", i, int'(aw), int'(x.w));
        end
        if (x.ct) cmp("tc", i, int'(atc), int'(x.tc));
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        rec_t x;
        forever begin
            @(negedge clk);
            if (sb[0].size() > 0) begin
                x = sb[0].pop_front();
                check(0, x, q1, wrap1, tc1);
            end
            if (sb[1].size() > 0) begin
                x = sb[1].pop_front();
                check(1, x, q3, wrap3, tc3);
            end
        end
    end

    // Drive one cycle of inputs and record what should be seen.
    task automatic cyc(input bit r, input bit e, input bit u,
                       input bit l, input int lv, input int mm,
                       input bit s);
        @(posedge clk);
        #1;
        reset    = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = lv[3:0];
        mod_max  = mm[3:0];
        sat_mode = s;
        for (int i = 0; i < 2; i++) begin
            rec_t x;
            bit tk, st;
            x.q  = mq[i];
            x.w  = mw[i];
            x.cs = known;
            x.ct = known && !r;
            tk   = e && ((ph[i] + 1) % pre[i] == 0);
            st   = tk && !l;
            x.tc = st && (u ? (mq[i] >= mm) : (mq[i] == 0));
            sb[i].push_back(x);
            mw[i] = 0;
            if (r) begin
                mq[i] = 0;
                ph[i] = 0;
            end else if (l) begin
                mq[i] = (lv > mm) ? mm : lv;
                ph[i] = 0;
            end else begin
                if (e) ph[i] = (ph[i] + 1) % pre[i];
                if (st) begin
                    if (u) begin
                        if (mq[i] < mm) mq[i] = mq[i] + 1;
                        else if (s) mq[i] = mm;
                        else begin
                            mq[i] = 0;
                            mw[i] = 1;
                        end
                    end else begin
                        if (mq[i] > mm) mq[i] = mm;
                        else if (mq[i] == 0) begin
                            if (!s) begin
                                mq[i] = mm;
                                mw[i] = 1;
                            end
                        end else mq[i] = mq[i] - 1;
                    end
                end
            end
        end
        if (r) known = 1;
    endtask

    task automatic rst();
        cyc(1, 0, 1, 0, 0, 15, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        mod_max  = 4'd15;
        sat_mode = 1'b0;

        // Full-range up count with wrap
        rst();
        rst();
        repeat (20) cyc(0, 1, 1, 0, 0, 15, 0);
        repeat (40) cyc(0, 1, 1, 0, 0, 15, 0);

        // Down count, mod 10, wrapping from 0
        rst();
        repeat (36) cyc(0, 1, 0, 0, 0, 9, 0);

        // Saturate up at 5 from 3
        cyc(0, 0, 1, 1, 3, 5, 1);
        repeat (12) cyc(0, 1, 1, 0, 0, 5, 1);
        // Saturate down at 0
        cyc(0, 0, 0, 1, 2, 5, 1);
        repeat (12) cyc(0, 1, 0, 0, 0, 5, 1);

        // Clamped load; load beats a simultaneous step
        cyc(0, 1, 1, 1, 12, 7, 0);
        cyc(0, 1, 1, 1, 3, 7, 0);
        repeat (2) cyc(0, 0, 1, 0, 0, 7, 0);

        // Prescaler phase: en gaps and a mid-phase load
        rst();
        repeat (7) cyc(0, 1, 1, 0, 0, 15, 0);
        repeat (2) cyc(0, 0, 1, 0, 0, 15, 0);
        repeat (5) cyc(0, 1, 1, 0, 0, 15, 0);
        cyc(0, 1, 1, 1, 4, 15, 0);
        repeat (7) cyc(0, 1, 1, 0, 0, 15, 0);

        // mod_max == 0: both directions wrap, sat holds
        rst();
        repeat (6) cyc(0, 1, 1, 0, 0, 0, 0);
        repeat (6) cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (6) cyc(0, 1, 1, 0, 0, 0, 1);

        // mod_max lowered below q at runtime
        cyc(0, 0, 1, 1, 12, 15, 0);
        repeat (4) cyc(0, 1, 1, 0, 0, 5, 0);
        cyc(0, 0, 1, 1, 12, 15, 0);
        repeat (4) cyc(0, 1, 0, 0, 0, 5, 0);
        cyc(0, 0, 1, 1, 12, 15, 0);
        repeat (4) cyc(0, 1, 1, 0, 0, 5, 1);

        // Reset mid-count with en high
        rst();
        repeat (18) cyc(0, 1, 1, 0, 0, 15, 0);
        cyc(1, 1, 1, 0, 0, 15, 0);
        repeat (8) cyc(0, 1, 1, 0, 0, 15, 0);

        // Randomized traffic
        cur_mm = 15;
        cur_s  = 0;
        repeat (3000) begin
            bit r, e, u, l;
            int lv;
            if ($urandom_range(0, 99) < 5) cur_mm = $urandom_range(0, 15);
            if ($urandom_range(0, 99) < 3) cur_s = ~cur_s;
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 85);
            u  = ($urandom_range(0, 99) < 60);
            l  = ($urandom_range(0, 99) < 5);
            lv = $urandom_range(0, 15);
            cyc(r, e, u, l, lv, cur_mm, cur_s);
        end

        repeat (3) @(negedge clk);
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0",
                     sb[0].size(), sb[1].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
